// File: rtl/dsp_test_pkg.sv
// Shared constants for the DSP48E1 test-vector sequencer: the vector field layout
// and the sequencer FSM state encoding.
package dsp_test_pkg;

    localparam int VEC_W   = 112;

    localparam int EXP_LSB = 64;
    localparam int EXP_W   = 48;
    localparam int OPM_LSB = 57;
    localparam int OPM_W   = 7;
    localparam int ALU_LSB = 53;
    localparam int ALU_W   = 4;
    localparam int INM_LSB = 48;
    localparam int INM_W   = 5;
    localparam int B_LSB   = 30;
    localparam int B_W     = 18;
    localparam int A_LSB   = 0;
    localparam int A_W     = 30;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dsp_vec_sequencer_if.sv
// BRAM read port plus the DSP input/output bundle that the sequencer drives and observes.
interface dsp_vec_sequencer_if
    import dsp_test_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic              bram_en;
    logic [ADDR_W-1:0] bram_addr;
    logic [VEC_W-1:0]  bram_dout;
    logic [A_W-1:0]    dsp_a;
    logic [B_W-1:0]    dsp_b;
    logic [INM_W-1:0]  dsp_inmode;
    logic [ALU_W-1:0]  dsp_alumode;
    logic [OPM_W-1:0]  dsp_opmode;
    logic [EXP_W-1:0]  dsp_p;

    modport master (
        output bram_en, bram_addr, dsp_a, dsp_b, dsp_inmode, dsp_alumode, dsp_opmode,
        input  bram_dout, dsp_p
    );

    modport slave (
        input  bram_en, bram_addr, dsp_a, dsp_b, dsp_inmode, dsp_alumode, dsp_opmode,
        output bram_dout, dsp_p
    );
endinterface

// File: rtl/dsp_exp_delay.sv
// Shift line that carries {valid, expected P, address} alongside the DSP pipeline so the
// tail entry lines up with the P value it describes.
module dsp_exp_delay
    import dsp_test_pkg::*;
#(
    parameter int DSP_LAT = 3,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_vld,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_vld,
    output logic [EXP_W-1:0]  o_exp,
    output logic [ADDR_W-1:0] o_addr
);
    logic [DSP_LAT-1:0]             r_vld;
    logic [DSP_LAT-1:0][EXP_W-1:0]  r_exp;
    logic [DSP_LAT-1:0][ADDR_W-1:0] r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_exp  <= '0;
            r_addr <= '0;
        end else begin
            r_vld[0]  <= i_vld;
            r_exp[0]  <= i_exp;
            r_addr[0] <= i_addr;
            for (int s = 1; s < DSP_LAT; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_exp[s]  <= r_exp[s-1];
                r_addr[s] <= r_addr[s-1];
            end
        end
    end

    assign o_vld  = r_vld[DSP_LAT-1];
    assign o_exp  = r_exp[DSP_LAT-1];
    assign o_addr = r_addr[DSP_LAT-1];
endmodule

// File: rtl/dsp_vec_sequencer.sv
// Streams test vectors from BRAM into a DSP48E1 multiply stage, one per cycle, and checks
// each P against the expected value carried alongside the DSP pipeline.
module dsp_vec_sequencer
    import dsp_test_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int NUM_VEC = 256,
    parameter int DSP_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_W:0]      err_cnt,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic                 first_err_vld,
    dsp_vec_sequencer_if.master  bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_VEC - 1);
    localparam int                DCNT_W     = $clog2(DSP_LAT + 2);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DSP_LAT + 1);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_addr, r_rd_addr, r_drv_addr;
    logic [DCNT_W-1:0]   r_drain_cnt;
    logic                r_rd_vld, r_drv_vld;
    logic [EXP_W-1:0]    r_drv_exp;
    logic [A_W-1:0]      r_a;
    logic [B_W-1:0]      r_b;
    logic [INM_W-1:0]    r_inmode;
    logic [ALU_W-1:0]    r_alumode;
    logic [OPM_W-1:0]    r_opmode;
    logic [ADDR_W:0]     r_err_cnt, w_err_nxt;
    logic [ADDR_W-1:0]   r_first_addr;
    logic                r_first_vld, r_pass;
    logic                w_bram_en, w_busy, w_done;
    logic                w_run_start, w_fetch_last, w_drain_last;
    logic                w_tail_vld, w_mismatch;
    logic [EXP_W-1:0]    w_tail_exp;
    logic [ADDR_W-1:0]   w_tail_addr;

    assign w_run_start  = (r_state == S_IDLE) && start;
    assign w_fetch_last = (r_state == S_FETCH) && (r_addr == LAST_ADDR);
    assign w_drain_last = (r_state == S_DRAIN) && (r_drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bram_en   = 1'b0;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                w_bram_en = 1'b1;
                if (w_fetch_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: if (w_drain_last) w_state_nxt = S_DONE;
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address wraps to 0 after the last issue so a full 2^ADDR_W run still ends clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (r_state == S_FETCH) r_addr <= w_fetch_last ? '0 : r_addr + 1'b1;
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_vld   <= 1'b0;
            r_rd_addr  <= '0;
            r_drv_vld  <= 1'b0;
            r_drv_exp  <= '0;
            r_drv_addr <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_inmode   <= '0;
            r_alumode  <= '0;
            r_opmode   <= '0;
        end else begin
            r_rd_vld  <= w_bram_en;
            r_rd_addr <= r_addr;
            r_drv_vld <= r_rd_vld;
            if (r_rd_vld) begin
                r_drv_exp  <= bus.bram_dout[EXP_LSB +: EXP_W];
                r_drv_addr <= r_rd_addr;
                r_a        <= bus.bram_dout[A_LSB   +: A_W];
                r_b        <= bus.bram_dout[B_LSB   +: B_W];
                r_inmode   <= bus.bram_dout[INM_LSB +: INM_W];
                r_alumode  <= bus.bram_dout[ALU_LSB +: ALU_W];
                r_opmode   <= bus.bram_dout[OPM_LSB +: OPM_W];
            end
        end
    end

    dsp_exp_delay #(.DSP_LAT(DSP_LAT), .ADDR_W(ADDR_W)) u_exp_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (r_drv_vld),
        .i_exp  (r_drv_exp),
        .i_addr (r_drv_addr),
        .o_vld  (w_tail_vld),
        .o_exp  (w_tail_exp),
        .o_addr (w_tail_addr)
    );

    assign w_mismatch = w_tail_vld && (bus.dsp_p != w_tail_exp);
    assign w_err_nxt  = r_err_cnt + (ADDR_W+1)'(w_mismatch);

    // The last compare lands on the final DRAIN edge, so pass is taken from the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_vld  <= 1'b0;
            r_pass       <= 1'b0;
        end else if (w_run_start) begin
            r_err_cnt    <= '0;
            r_first_addr <= '0;
            r_first_vld  <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            r_err_cnt <= w_err_nxt;
            if (w_mismatch && !r_first_vld) begin
                r_first_addr <= w_tail_addr;
                r_first_vld  <= 1'b1;
            end
            if (w_drain_last) r_pass <= (w_err_nxt == '0);
        end
    end

    assign busy            = w_busy;
    assign done            = w_done;
    assign pass            = r_pass;
    assign err_cnt         = r_err_cnt;
    assign first_err_addr  = r_first_addr;
    assign first_err_vld   = r_first_vld;
    assign bus.bram_en     = w_bram_en;
    assign bus.bram_addr   = r_addr;
    assign bus.dsp_a       = r_a;
    assign bus.dsp_b       = r_b;
    assign bus.dsp_inmode  = r_inmode;
    assign bus.dsp_alumode = r_alumode;
    assign bus.dsp_opmode  = r_opmode;
endmodule

// File: tb/tb_dsp_vec_sequencer.sv
// Directed bench for dsp_vec_sequencer with a behavioural BRAM and a 3-stage signed
// 25x18 multiply standing in for the DSP48E1 (A/B reg, M reg, P reg).
module tb_dsp_vec_sequencer;
    import dsp_test_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int NUM_VEC = 4;
    localparam int DSP_LAT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, pass, first_err_vld;
    logic [ADDR_W:0]   err_cnt;
    logic [ADDR_W-1:0] first_err_addr;

    dsp_vec_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    dsp_vec_sequencer #(.ADDR_W(ADDR_W), .NUM_VEC(NUM_VEC), .DSP_LAT(DSP_LAT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .first_err_vld  (first_err_vld),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    logic [VEC_W-1:0] mem [0:(1<<ADDR_W)-1];
    always_ff @(posedge clk) if (bus.bram_en) bus.bram_dout <= mem[bus.bram_addr];

    logic [24:0] m_a1;
    logic [17:0] m_b1;
    logic [47:0] m_m, m_p;
    always_ff @(posedge clk) begin
        m_a1 <= bus.dsp_a[24:0];
        m_b1 <= bus.dsp_b;
        m_m  <= {{23{m_a1[24]}}, m_a1} * {{30{m_b1[17]}}, m_b1};
        m_p  <= m_m;
    end
    assign bus.dsp_p = m_p;

    int total = 0;
    int bad   = 0;

    int          r_dcyc, r_ndone, r_err;
    logic        r_pass, r_fev;
    logic [7:0]  r_fea;

    function automatic logic [VEC_W-1:0] mkvec(input logic [29:0] a, input logic [17:0] b,
                                               input logic [47:0] e);
        return {e, 7'b0000101, 4'b0000, 5'b00000, b, a};
    endfunction

    task automatic load_clean();
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        mem[0] = mkvec(30'd3, 18'd5, 48'd15);
        mem[1] = mkvec(30'h3FFFFFFE, 18'd7, 48'hFFFFFFFFFFF2);
        mem[2] = mkvec(30'd1000, 18'd1000, 48'd1000000);
        mem[3] = mkvec(30'd0, 18'h1FFFF, 48'd0);
    endtask

    // Cycle 0 is the IDLE cycle with start high; loop index i is the cycle number.
    task automatic do_run(input bit pulse_mid);
        r_dcyc = -1; r_ndone = 0; r_err = -1; r_pass = 1'bx; r_fev = 1'bx; r_fea = 'x;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (pulse_mid && i == 2) start = 1'b1;
            if (pulse_mid && i == 3) start = 1'b0;
            if (done) begin
                if (r_ndone == 0) begin
                    r_dcyc = i; r_err = int'(err_cnt); r_pass = pass;
                    r_fev = first_err_vld; r_fea = first_err_addr;
                end
                r_ndone++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom);
            @(negedge clk);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
        total++; if (pass !== 1'b0) begin bad++; $display("FAIL rst_pass got=%0b want=0", pass); end
        total++; if (err_cnt !== '0) begin bad++; $display("FAIL rst_err got=%0d want=0", err_cnt); end
        total++; if ({first_err_vld, first_err_addr} !== '0) begin bad++; $display("FAIL rst_first got=%0h want=0", {first_err_vld, first_err_addr}); end
        total++; if ({bus.bram_en, bus.bram_addr} !== '0) begin bad++; $display("FAIL rst_bram got=%0h want=0", {bus.bram_en, bus.bram_addr}); end
        total++; if ({bus.dsp_a, bus.dsp_b, bus.dsp_inmode, bus.dsp_alumode, bus.dsp_opmode} !== '0) begin
            bad++; $display("FAIL rst_drive got=%0h want=0", {bus.dsp_a, bus.dsp_b, bus.dsp_inmode, bus.dsp_alumode, bus.dsp_opmode}); end
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean();
        load_clean();
        do_run(1'b0);
        total++; if (r_dcyc !== 10) begin bad++; $display("FAIL clean_done_cycle got=%0d want=10", r_dcyc); end
        total++; if (r_ndone !== 1) begin bad++; $display("FAIL clean_ndone got=%0d want=1", r_ndone); end
        total++; if (r_err !== 0) begin bad++; $display("FAIL clean_err got=%0d want=0", r_err); end
        total++; if (r_pass !== 1'b1) begin bad++; $display("FAIL clean_pass got=%0b want=1", r_pass); end
        total++; if (r_fev !== 1'b0) begin bad++; $display("FAIL clean_fev got=%0b want=0", r_fev); end
        total++; if (pass !== 1'b1) begin bad++; $display("FAIL clean_pass_held got=%0b want=1", pass); end
    endtask

    task automatic test_one_err();
        load_clean();
        mem[2] = mkvec(30'd1000, 18'd1000, 48'd999999);
        do_run(1'b0);
        total++; if (r_dcyc !== 10) begin bad++; $display("FAIL err1_done_cycle got=%0d want=10", r_dcyc); end
        total++; if (r_err !== 1) begin bad++; $display("FAIL err1_cnt got=%0d want=1", r_err); end
        total++; if (r_fea !== 8'd2) begin bad++; $display("FAIL err1_addr got=%0d want=2", r_fea); end
        total++; if (r_fev !== 1'b1) begin bad++; $display("FAIL err1_fev got=%0b want=1", r_fev); end
        total++; if (r_pass !== 1'b0) begin bad++; $display("FAIL err1_pass got=%0b want=0", r_pass); end
    endtask

    task automatic test_two_err();
        load_clean();
        mem[1] = mkvec(30'h3FFFFFFE, 18'd7, 48'hFFFFFFFFFFF3);
        mem[3] = mkvec(30'd0, 18'h1FFFF, 48'h800000000000);
        do_run(1'b0);
        total++; if (r_err !== 2) begin bad++; $display("FAIL err2_cnt got=%0d want=2", r_err); end
        total++; if (r_fea !== 8'd1) begin bad++; $display("FAIL err2_addr got=%0d want=1", r_fea); end
        total++; if (r_pass !== 1'b0) begin bad++; $display("FAIL err2_pass got=%0b want=0", r_pass); end
    endtask

    task automatic test_start_ignored();
        load_clean();
        do_run(1'b1);
        total++; if (r_ndone !== 1) begin bad++; $display("FAIL ign_ndone got=%0d want=1", r_ndone); end
        total++; if (r_dcyc !== 10) begin bad++; $display("FAIL ign_done_cycle got=%0d want=10", r_dcyc); end
        total++; if (r_err !== 0) begin bad++; $display("FAIL ign_err got=%0d want=0", r_err); end
    endtask

    task automatic test_back_to_back();
        int nd = 0, d1 = -1, d2 = -1, e1 = -1, e2 = -1;
        logic p1 = 1'b0, p2 = 1'b0;
        load_clean();
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) begin d1 = i; e1 = int'(err_cnt); p1 = pass; end
                if (nd == 2) begin d2 = i; e2 = int'(err_cnt); p2 = pass; start = 1'b0; end
            end
        end
        start = 1'b0;
        total++; if (nd !== 2) begin bad++; $display("FAIL b2b_ndone got=%0d want=2", nd); end
        total++; if (d1 !== 10) begin bad++; $display("FAIL b2b_done1 got=%0d want=10", d1); end
        total++; if (d2 !== 21) begin bad++; $display("FAIL b2b_done2 got=%0d want=21", d2); end
        total++; if (e1 !== 0 || e2 !== 0) begin bad++; $display("FAIL b2b_err got=%0d,%0d want=0,0", e1, e2); end
        total++; if (p1 !== 1'b1 || p2 !== 1'b1) begin bad++; $display("FAIL b2b_pass got=%0b,%0b want=1,1", p1, p2); end
    endtask

    task automatic test_reset_mid();
        int nd = 0;
        load_clean();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.bram_addr !== 8'd2) begin bad++; $display("FAIL mid_addr got=%0d want=2", bus.bram_addr); end
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || bus.bram_en !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b%0b want=00", busy, bus.bram_en); end
        total++; if (bus.bram_addr !== '0 || bus.dsp_a !== '0) begin bad++; $display("FAIL mid_regs got=%0h,%0h want=0,0", bus.bram_addr, bus.dsp_a); end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        total++; if (nd !== 0) begin bad++; $display("FAIL mid_nodone got=%0d want=0", nd); end
        do_run(1'b0);
        total++; if (r_ndone !== 1 || r_err !== 0 || r_pass !== 1'b1) begin
            bad++; $display("FAIL mid_rerun got=nd%0d err%0d pass%0b want=nd1 err0 pass1", r_ndone, r_err, r_pass); end
    endtask

    initial begin
        load_clean();
        test_reset();
        test_clean();
        test_one_err();
        test_two_err();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
